// File: rtl/pipe_ex_drain_if.sv
// Handshake bundle between the pipe_ex issue source, the result consumer and pipe_ex_drain.
// The drain_cnt signal exists only when PIPE_DRAIN_CNT_EN is defined.
interface pipe_ex_drain_if #(
   parameter int unsigned N     = 10,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic          iss_valid;
   logic          iss_ready;
   logic [N-1:0]  pipe_f;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_data;
   logic [CW-1:0] inflight;
   logic [CW-1:0] count;
`ifdef PIPE_DRAIN_CNT_EN
   logic [15:0]   drain_cnt;
`endif

`ifdef PIPE_DRAIN_CNT_EN
   modport master (
      output iss_valid, pipe_f, out_ready,
      input  iss_ready, out_valid, out_data, inflight, count, drain_cnt
   );
   modport slave (
      input  iss_valid, pipe_f, out_ready,
      output iss_ready, out_valid, out_data, inflight, count, drain_cnt
   );
`else
   modport master (
      output iss_valid, pipe_f, out_ready,
      input  iss_ready, out_valid, out_data, inflight, count
   );
   modport slave (
      input  iss_valid, pipe_f, out_ready,
      output iss_ready, out_valid, out_data, inflight, count
   );
`endif
endinterface

// File: rtl/pipe_ex_drain.sv
// Credit-gated issue and in-order result capture for the fixed-latency pipe_ex datapath.
// Optional PIPE_DRAIN_CNT_EN adds a 16-bit wrapping pop counter (drain_cnt).
module pipe_ex_drain #(
   parameter int unsigned N     = 10,
   parameter int unsigned LAT   = 3,
   parameter int unsigned DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   pipe_ex_drain_if.slave bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [CW-1:0] DepthC = CW'(DEPTH);

   logic [LAT-1:0] vld_sr_q, vld_sr_d;
   logic [CW-1:0]  inflight_q, inflight_d;
   logic [CW-1:0]  count_q, count_d;
   logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [N-1:0]   mem_q [DEPTH];
   logic [CW:0]    occ;
   logic           fire, cap, wr, pop;

   // Credits cover both queued and in-flight results, so every issue has a slot waiting.
   assign occ           = {1'b0, count_q} + {1'b0, inflight_q};
   assign bus.iss_ready = occ < {1'b0, DepthC};
   assign fire          = bus.iss_valid & bus.iss_ready;
   assign cap           = vld_sr_q[LAT-1];
   assign wr            = cap & (count_q != DepthC);
   assign bus.out_valid = count_q != '0;
   assign pop           = bus.out_valid & bus.out_ready;
   assign bus.out_data  = mem_q[rd_ptr_q];
   assign bus.inflight  = inflight_q;
   assign bus.count     = count_q;

   if (LAT == 1) begin : g_sr1
      assign vld_sr_d = fire;
   end else begin : g_srn
      assign vld_sr_d = {vld_sr_q[LAT-2:0], fire};
   end

   always_comb begin
      inflight_d = inflight_q;
      unique case ({fire, cap})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
      count_d = count_q;
      unique case ({wr, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_sr_q   <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         vld_sr_q   <= vld_sr_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage is reset too so out_data reads zero straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr) begin
         mem_q[wr_ptr_q] <= bus.pipe_f;
      end
   end

`ifdef PIPE_DRAIN_CNT_EN
   logic [15:0] drain_cnt_q;
   assign bus.drain_cnt = drain_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drain_cnt_q <= '0;
      end else if (pop) begin
         drain_cnt_q <= drain_cnt_q + 16'd1;
      end
   end
`endif
endmodule
